// File: rtl/arm_pkg.sv
// Shared definitions for the ID-stage hazard scheduler: condition code
// constants, register index width and the scoreboard slot layout.
package arm_pkg;

    localparam int         REG_W   = 4;
    localparam logic [3:0] COND_AL = 4'b1110;

    // One in-flight instruction as seen by the scoreboard.
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic [REG_W-1:0] dest;
        logic             mem_read;
        logic             status_en;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/hazard_sb_slot.sv
// One registered scoreboard slot. Hold wins over bubble, bubble wins over load.
module hazard_sb_slot
    import arm_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     hold,
    input  logic     bubble,
    input  sb_slot_t slot_i,
    output sb_slot_t slot_o
);

    sb_slot_t slot_q;
    sb_slot_t slot_d;

    // Next-slot selection: keep, insert a bubble, or take the upstream entry.
    always_comb begin
        slot_d = slot_q;
        if (!hold) begin
            slot_d = bubble ? SLOT_EMPTY : slot_i;
        end
    end

    // Slot register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/hazard_scheduler.sv
// ID-stage issue scheduler. Tracks instructions in EXE..MEM, detects RAW
// register and flag dependencies, and drives the IF/ID freeze/flush controls
// plus a saturating stall-cycle counter.
module hazard_scheduler
    import arm_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int FWD_EN = 0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_cond_al,
    input  logic             id_wb_en,
    input  logic [3:0]       id_dest,
    input  logic             id_mem_read,
    input  logic             id_status_en,
    input  logic             branch_taken,
    input  logic             mem_stall,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic [CNT_W-1:0] stall_count
);

    sb_slot_t         slot_q  [DEPTH];
    sb_slot_t         slot_in [DEPTH];
    sb_slot_t         id_entry;
    logic [DEPTH-1:0] match_k;
    logic [DEPTH-1:0] flag_k;
    logic             raw;
    logic             sts;
    logic             issue_bubble;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    // Entry that the ID instruction would occupy in slot 0 if it issues.
    always_comb begin
        id_entry.valid     = 1'b1;
        id_entry.wb_en     = id_wb_en;
        id_entry.dest      = id_dest;
        id_entry.mem_read  = id_mem_read;
        id_entry.status_en = id_status_en;
    end

    assign issue_bubble = hazard | branch_taken | ~id_valid;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_slot
            if (k == 0) begin : g_head
                assign slot_in[k] = id_entry;
            end else begin : g_tail
                assign slot_in[k] = slot_q[k-1];
            end
            hazard_sb_slot u_slot (
                .clk    (clk),
                .rst    (rst),
                .hold   (mem_stall),
                .bubble ((k == 0) ? issue_bubble : 1'b0),
                .slot_i (slot_in[k]),
                .slot_o (slot_q[k])
            );
        end
    endgenerate

    // Per-slot register and flag dependency compare against the ID operands.
    always_comb begin
        match_k = '0;
        flag_k  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_k[i] = slot_q[i].valid & slot_q[i].wb_en &
                         ((slot_q[i].dest == id_src1) |
                          (id_two_src & (slot_q[i].dest == id_src2)));
            flag_k[i]  = slot_q[i].valid & slot_q[i].status_en;
        end
    end

    // With forwarding only a load still in EXE cannot be bypassed.
    assign raw = (FWD_EN != 0) ? (match_k[0] & slot_q[0].mem_read) : (|match_k);

    // Flags are never forwarded, so any pending flag setter blocks a conditional op.
    assign sts = ~id_cond_al & (|flag_k);

    assign hazard = id_valid & ~branch_taken & (raw | sts);
    assign flush  = branch_taken & ~mem_stall;
    assign freeze = mem_stall | hazard;

    // Saturating count of issue-stall cycles; frozen while memory holds the pipe.
    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard && !mem_stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler. Three instances share the stimulus:
// u0 (DEPTH=2, no forwarding), u1 (forwarding), u2 (4-bit counter).
module tb_hazard_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_two_src, id_cond_al, id_wb_en, id_mem_read, id_status_en;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       branch_taken, mem_stall;

    logic        h0, fz0, fl0, h1, fz1, fl1, h2, fz2, fl2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    typedef struct packed {
        logic h;
        logic fz;
        logic fl;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scheduler #(.DEPTH(2), .FWD_EN(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_cond_al(id_cond_al), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .id_status_en(id_status_en),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .hazard(h0), .freeze(fz0), .flush(fl0), .stall_count(cnt0));

    hazard_scheduler #(.DEPTH(2), .FWD_EN(1), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_cond_al(id_cond_al), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .id_status_en(id_status_en),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .hazard(h1), .freeze(fz1), .flush(fl1), .stall_count(cnt1));

    hazard_scheduler #(.DEPTH(2), .FWD_EN(0), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_cond_al(id_cond_al), .id_wb_en(id_wb_en),
        .id_dest(id_dest), .id_mem_read(id_mem_read), .id_status_en(id_status_en),
        .branch_taken(branch_taken), .mem_stall(mem_stall),
        .hazard(h2), .freeze(fz2), .flush(fl2), .stall_count(cnt2));

    task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                          input logic two, input logic al, input logic wb,
                          input logic [3:0] d, input logic mr, input logic st);
        id_valid     = v;
        id_src1      = s1;
        id_src2      = s2;
        id_two_src   = two;
        id_cond_al   = al;
        id_wb_en     = wb;
        id_dest      = d;
        id_mem_read  = mr;
        id_status_en = st;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        branch_taken = 1'b0;
        mem_stall    = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Push the expected controls for the current inputs, compare, then advance one edge.
    task automatic step(input string tag, input logic eh, input logic efz, input logic efl);
        exp_t e;
        exp_t o;
        exp_q.push_back(exp_t'({eh, efz, efl}));
        #1;
        e = exp_q.pop_front();
        case (sel)
            1:       o = exp_t'({h1, fz1, fl1});
            2:       o = exp_t'({h2, fz2, fl2});
            default: o = exp_t'({h0, fz0, fl0});
        endcase
        total++;
        assert (o.h === e.h) else begin
            bad++;
            $error("FAIL %s hazard: got %b want %b", tag, o.h, e.h);
        end
        total++;
        assert (o.fz === e.fz) else begin
            bad++;
            $error("FAIL %s freeze: got %b want %b", tag, o.fz, e.fz);
        end
        total++;
        assert (o.fl === e.fl) else begin
            bad++;
            $error("FAIL %s flush: got %b want %b", tag, o.fl, e.fl);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s stall_count: got %0d want %0d", tag, obs, expv);
        end
    endtask

    initial begin
        int exp_c0;
        int exp_c2;

        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 1. reset with slots pre-filled by two ADD R1
        sel = 0;
        set_id(1, 4'd2, 4'd3, 1, 1, 1, 4'd1, 0, 0);
        step("fill0", 0, 0, 0);
        set_id(1, 4'd0, 4'd0, 0, 1, 1, 4'd1, 0, 0);
        step("fill1", 0, 0, 0);
        idle();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("rst_idle", 0, 0, 0);
        chk_cnt("rst_u0", cnt0, 16'd0);
        chk_cnt("rst_u2", {12'd0, cnt2}, 16'd0);
        set_id(1, 4'd1, 4'd1, 1, 1, 1, 4'd2, 0, 0);
        step("rst_cleared", 0, 0, 0);

        // 2. RAW without forwarding: ADD R1 ; SUB R2,R1,R3
        do_reset();
        sel = 0;
        set_id(1, 4'd4, 4'd5, 1, 1, 1, 4'd1, 0, 0);
        step("raw_add", 0, 0, 0);
        set_id(1, 4'd1, 4'd3, 1, 1, 1, 4'd2, 0, 0);
        step("raw_c1", 1, 1, 0);
        step("raw_c2", 1, 1, 0);
        chk_cnt("raw_cnt", cnt0, 16'd2);
        step("raw_issue", 0, 0, 0);
        set_id(1, 4'd2, 4'd0, 0, 1, 1, 4'd6, 0, 0);
        step("raw_next", 1, 1, 0);

        // reset in the middle of a stall; the held SUB issues right after
        do_reset();
        set_id(1, 4'd4, 4'd5, 1, 1, 1, 4'd1, 0, 0);
        step("mrst_add", 0, 0, 0);
        set_id(1, 4'd1, 4'd3, 1, 1, 1, 4'd2, 0, 0);
        step("mrst_stall", 1, 1, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step("mrst_issue", 0, 0, 0);
        chk_cnt("mrst_cnt", cnt0, 16'd0);

        // 3. load-use with forwarding
        do_reset();
        sel = 1;
        set_id(1, 4'd0, 4'd0, 0, 1, 1, 4'd4, 1, 0);
        step("ldu_ldr", 0, 0, 0);
        set_id(1, 4'd4, 4'd4, 1, 1, 1, 4'd5, 0, 0);
        step("ldu_c1", 1, 1, 0);
        step("ldu_issue", 0, 0, 0);
        chk_cnt("ldu_cnt", cnt1, 16'd1);
        set_id(1, 4'd6, 4'd7, 1, 1, 1, 4'd1, 0, 0);
        step("fwd_add", 0, 0, 0);
        set_id(1, 4'd1, 4'd3, 1, 1, 1, 4'd2, 0, 0);
        step("fwd_sub", 0, 0, 0);

        // 4. status hazard: CMP ; MOVEQ, then CMP ; MOVAL
        do_reset();
        sel = 0;
        set_id(1, 4'd1, 4'd2, 1, 1, 0, 4'd0, 0, 1);
        step("sts_cmp", 0, 0, 0);
        set_id(1, 4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 0);
        step("sts_c1", 1, 1, 0);
        step("sts_c2", 1, 1, 0);
        step("sts_issue", 0, 0, 0);
        do_reset();
        set_id(1, 4'd1, 4'd2, 1, 1, 0, 4'd0, 0, 1);
        step("al_cmp", 0, 0, 0);
        set_id(1, 4'd0, 4'd0, 0, 1, 1, 4'd0, 0, 0);
        step("al_mov", 0, 0, 0);

        // 5. branch taken while ID has a RAW dependency
        do_reset();
        set_id(1, 4'd4, 4'd5, 1, 1, 1, 4'd1, 0, 0);
        step("br_add", 0, 0, 0);
        set_id(1, 4'd1, 4'd0, 0, 1, 1, 4'd7, 0, 0);
        branch_taken = 1'b1;
        step("br_flush", 0, 0, 1);
        branch_taken = 1'b0;
        set_id(1, 4'd7, 4'd0, 0, 1, 1, 4'd8, 0, 0);
        step("br_bubble", 0, 0, 0);
        chk_cnt("br_cnt", cnt0, 16'd0);

        // 6. memory stall with a pending branch and an in-flight ADD
        do_reset();
        set_id(1, 4'd4, 4'd5, 1, 1, 1, 4'd1, 0, 0);
        step("ms_add", 0, 0, 0);
        set_id(1, 4'd1, 4'd0, 0, 1, 1, 4'd2, 0, 0);
        branch_taken = 1'b1;
        mem_stall    = 1'b1;
        step("ms_c1", 0, 1, 0);
        step("ms_c2", 0, 1, 0);
        step("ms_c3", 0, 1, 0);
        mem_stall = 1'b0;
        step("ms_release", 0, 0, 1);
        branch_taken = 1'b0;
        step("ms_held_slot", 1, 1, 0);
        chk_cnt("ms_cnt", cnt0, 16'd1);

        // counter holds while a hazard coincides with a memory stall
        do_reset();
        set_id(1, 4'd4, 4'd5, 1, 1, 1, 4'd1, 0, 0);
        step("msh_add", 0, 0, 0);
        set_id(1, 4'd1, 4'd0, 0, 1, 1, 4'd2, 0, 0);
        mem_stall = 1'b1;
        step("msh_c1", 1, 1, 0);
        step("msh_c2", 1, 1, 0);
        chk_cnt("msh_frozen", cnt0, 16'd0);
        mem_stall = 1'b0;
        step("msh_r1", 1, 1, 0);
        step("msh_r2", 1, 1, 0);
        step("msh_issue", 0, 0, 0);
        chk_cnt("msh_cnt", cnt0, 16'd2);

        // R15 matches like any other register; src2 only counts when two_src
        do_reset();
        set_id(1, 4'd0, 4'd0, 0, 1, 1, 4'd15, 0, 0);
        step("r15_prod", 0, 0, 0);
        set_id(1, 4'd0, 4'd15, 0, 1, 0, 4'd0, 0, 0);
        step("r15_one_src", 0, 0, 0);
        set_id(1, 4'd0, 4'd15, 1, 1, 1, 4'd3, 0, 0);
        step("r15_two_src", 1, 1, 0);

        // 7. saturation: a dependency chain gives 20 stall cycles
        do_reset();
        sel    = 2;
        exp_c0 = 0;
        exp_c2 = 0;
        set_id(1, 4'd0, 4'd0, 0, 1, 1, 4'd1, 0, 0);
        step("sat_head", 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            set_id(1, 4'(i), 4'd0, 0, 1, 1, 4'(i + 1), 0, 0);
            for (int c = 0; c < 2; c++) begin
                step("sat_stall", 1, 1, 0);
                exp_c0++;
                if (exp_c2 < 15) exp_c2++;
            end
            step("sat_issue", 0, 0, 0);
            if (i == 7) chk_cnt("sat_mid", {12'd0, cnt2}, 16'(exp_c2));
        end
        chk_cnt("sat_u2", {12'd0, cnt2}, 16'(exp_c2));
        chk_cnt("sat_u2_max", {12'd0, cnt2}, 16'd15);
        chk_cnt("sat_u0", cnt0, 16'(exp_c0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
